// File: rtl/npc_ctrl_fsm_pkg.sv
// Shared types for the NPC control sequencer: decoder optype/option codes,
// FSM states, trap causes and the 3-bit debug view of the state.
package npc_ctrl_fsm_pkg;

  typedef enum logic [2:0] {
    TYPE_R = 3'd0,
    TYPE_I = 3'd1,
    TYPE_S = 3'd2,
    TYPE_B = 3'd3,
    TYPE_U = 3'd4,
    TYPE_J = 3'd5,
    NOTYPE = 3'd7
  } optype_e;

  typedef enum logic [5:0] {
    inst_lui, inst_auipc, inst_jal, inst_jalr,
    inst_beq, inst_bne, inst_blt, inst_bge, inst_bltu, inst_bgeu,
    inst_lb, inst_lh, inst_lw, inst_lbu, inst_lhu,
    inst_sb, inst_sh, inst_sw,
    inst_addi, inst_slti, inst_sltiu, inst_xori, inst_ori, inst_andi,
    inst_slli, inst_srli, inst_srai,
    inst_add, inst_sub, inst_sll, inst_slt, inst_sltu,
    inst_xor, inst_srl, inst_sra, inst_or, inst_and,
    inst_ecall, inst_ebreak, inst_csrrw, inst_csrrs, inst_mret
  } option_e;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_IWAIT, S_DECODE, S_EXEC,
    S_MEM, S_MWAIT, S_WB, S_HALT, S_TRAP
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_IFU_ERR = 2'd0,
    CAUSE_LSU_ERR = 2'd1,
    CAUSE_TIMEOUT = 2'd2,
    CAUSE_ILLEGAL = 2'd3
  } cause_e;

  // Ten states share a 3-bit debug port: each request/wait pair folds into one code.
  function automatic logic [2:0] state_dbg(state_e s);
    case (s)
      S_IDLE:           return 3'd0;
      S_FETCH, S_IWAIT: return 3'd1;
      S_DECODE:         return 3'd2;
      S_EXEC:           return 3'd3;
      S_MEM, S_MWAIT:   return 3'd4;
      S_WB:             return 3'd5;
      S_HALT:           return 3'd6;
      default:          return 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/npc_ctrl_fsm_if.sv
// Instruction-fetch and load/store valid/ready bus between the sequencer
// (master) and the memory side (slave).
interface npc_ctrl_fsm_if;
  logic        ifu_req_valid_o;
  logic        ifu_req_ready_i;
  logic [31:0] ifu_addr_o;
  logic        ifu_resp_valid_i;
  logic [31:0] ifu_resp_data_i;
  logic        ifu_resp_err_i;
  logic        lsu_req_valid_o;
  logic        lsu_req_ready_i;
  logic        lsu_req_wen_o;
  logic        lsu_resp_valid_i;
  logic        lsu_resp_err_i;

  modport master (
    output ifu_req_valid_o, ifu_addr_o, lsu_req_valid_o, lsu_req_wen_o,
    input  ifu_req_ready_i, ifu_resp_valid_i, ifu_resp_data_i, ifu_resp_err_i,
    input  lsu_req_ready_i, lsu_resp_valid_i, lsu_resp_err_i
  );

  modport slave (
    input  ifu_req_valid_o, ifu_addr_o, lsu_req_valid_o, lsu_req_wen_o,
    output ifu_req_ready_i, ifu_resp_valid_i, ifu_resp_data_i, ifu_resp_err_i,
    output lsu_req_ready_i, lsu_resp_valid_i, lsu_resp_err_i
  );
endinterface

// File: rtl/npc_ctrl_fsm_classify.sv
// Combinational classification of the decoder's optype/option into the
// control attributes the sequencer needs.
module npc_ctrl_classify
  import npc_ctrl_fsm_pkg::*;
(
  input  logic [2:0] optype,
  input  logic [5:0] option,
  output logic       is_mem,
  output logic       is_store,
  output logic       rf_we,
  output logic       csr_we,
  output logic       is_halt,
  output logic       illegal
);

  always_comb begin
    illegal  = !(optype inside {TYPE_R, TYPE_I, TYPE_S, TYPE_B, TYPE_U, TYPE_J});
    is_store = option inside {inst_sb, inst_sh, inst_sw};
    is_mem   = is_store || (option inside {inst_lb, inst_lh, inst_lw, inst_lbu, inst_lhu});
    csr_we   = option inside {inst_csrrw, inst_csrrs};
    is_halt  = !illegal && (option == inst_ebreak);
    // System ops ride on I-type but never write rd, except the CSR reads.
    rf_we    = ((optype inside {TYPE_R, TYPE_I, TYPE_U, TYPE_J}) &&
                !(option inside {inst_ecall, inst_ebreak, inst_mret})) || csr_we;
  end

endmodule

// File: rtl/npc_ctrl_fsm.sv
// Multi-cycle NPC sequencer: fetch over valid/ready, decode settle, execute,
// optional memory access, writeback; detects halt, bus errors, timeouts, illegal ops.
module npc_ctrl_fsm
  import npc_ctrl_fsm_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 16,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             start_i,
  npc_ctrl_fsm_if.master   bus,
  output logic [31:0]      ir_o,
  input  logic [2:0]       decode_optype_i,
  input  logic [5:0]       decode_option_i,
  input  logic [31:0]      next_pc_i,
  output logic             rf_wen_o,
  output logic             csr_wen_o,
  output logic [31:0]      pc_o,
  output logic             halt_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] inst_cnt_o
);

  localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

  state_e             state, state_nxt;
  cause_e             cause_q, cause_nxt;
  logic [31:0]        pc_q, ir_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [TMO_W-1:0]   tmo_q;
  logic               ir_load, pc_load, cnt_inc, trap_set;
  logic               waiting, tmo_hit;
  logic               is_mem, is_store, rf_we, csr_we, is_halt, illegal;

  npc_ctrl_classify u_classify (
    .optype   (decode_optype_i),
    .option   (decode_option_i),
    .is_mem   (is_mem),
    .is_store (is_store),
    .rf_we    (rf_we),
    .csr_we   (csr_we),
    .is_halt  (is_halt),
    .illegal  (illegal)
  );

  assign waiting = state inside {S_FETCH, S_IWAIT, S_MEM, S_MWAIT};
  assign tmo_hit = waiting && (tmo_q == TMO_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    cause_nxt = CAUSE_IFU_ERR;
    trap_set  = 1'b0;
    ir_load   = 1'b0;
    pc_load   = 1'b0;
    cnt_inc   = 1'b0;
    case (state)
      S_IDLE: if (start_i) state_nxt = S_FETCH;
      S_FETCH: begin
        if (bus.ifu_req_ready_i) state_nxt = S_IWAIT;
        else if (tmo_hit) begin state_nxt = S_TRAP; trap_set = 1'b1; cause_nxt = CAUSE_TIMEOUT; end
      end
      S_IWAIT: begin
        // A response in its final allowed cycle still wins over the timeout.
        if (bus.ifu_resp_valid_i) begin
          if (bus.ifu_resp_err_i) begin state_nxt = S_TRAP; trap_set = 1'b1; cause_nxt = CAUSE_IFU_ERR; end
          else begin state_nxt = S_DECODE; ir_load = 1'b1; end
        end else if (tmo_hit) begin state_nxt = S_TRAP; trap_set = 1'b1; cause_nxt = CAUSE_TIMEOUT; end
      end
      S_DECODE: begin
        if (illegal) begin state_nxt = S_TRAP; trap_set = 1'b1; cause_nxt = CAUSE_ILLEGAL; end
        else if (is_halt) begin state_nxt = S_HALT; cnt_inc = 1'b1; end
        else state_nxt = S_EXEC;
      end
      S_EXEC: state_nxt = is_mem ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.lsu_req_ready_i) state_nxt = S_MWAIT;
        else if (tmo_hit) begin state_nxt = S_TRAP; trap_set = 1'b1; cause_nxt = CAUSE_TIMEOUT; end
      end
      S_MWAIT: begin
        if (bus.lsu_resp_valid_i) begin
          if (bus.lsu_resp_err_i) begin state_nxt = S_TRAP; trap_set = 1'b1; cause_nxt = CAUSE_LSU_ERR; end
          else state_nxt = S_WB;
        end else if (tmo_hit) begin state_nxt = S_TRAP; trap_set = 1'b1; cause_nxt = CAUSE_TIMEOUT; end
      end
      S_WB: begin
        state_nxt = S_FETCH;
        pc_load   = 1'b1;
        cnt_inc   = 1'b1;
      end
      S_HALT, S_TRAP: state_nxt = state;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state   <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      cause_q <= CAUSE_IFU_ERR;
    end else begin
      state <= state_nxt;
      if (ir_load)  ir_q    <= bus.ifu_resp_data_i;
      if (pc_load)  pc_q    <= next_pc_i;
      if (cnt_inc)  cnt_q   <= cnt_q + CNT_W'(1);
      if (trap_set) cause_q <= cause_nxt;
      if (state_nxt != state) tmo_q <= '0;
      else if (waiting)       tmo_q <= tmo_q + TMO_W'(1);
    end
  end

  assign bus.ifu_req_valid_o = (state == S_FETCH);
  assign bus.ifu_addr_o      = pc_q;
  assign bus.lsu_req_valid_o = (state == S_MEM);
  assign bus.lsu_req_wen_o   = (state == S_MEM) && is_store;
  assign rf_wen_o            = (state == S_WB) && rf_we;
  assign csr_wen_o           = (state == S_WB) && csr_we;
  assign halt_o              = (state == S_HALT);
  assign trap_o              = (state == S_TRAP);
  assign trap_cause_o        = cause_q;
  assign pc_o                = pc_q;
  assign ir_o                = ir_q;
  assign inst_cnt_o          = cnt_q;
  assign state_o             = state_dbg(state);

endmodule

// File: tb/tb_npc_ctrl_fsm.sv
// Directed bench for npc_ctrl_fsm: a small decoder model and bus responder,
// with per-instruction expectations queued before driving and checked on retire.
module tb_npc_ctrl_fsm;
  import npc_ctrl_fsm_pkg::*;

  typedef struct {
    int          cyc;
    int          rf;
    int          csr;
    int          lval;
    int          lwen;
    logic [31:0] pc;
    logic [31:0] cnt;
    logic [2:0]  st;
    logic        halt;
    logic        trap;
    logic [1:0]  cause;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  dec_type;
  logic [5:0]  dec_opt;
  logic [31:0] next_pc = '0;
  logic [31:0] ir, pc, cnt;
  logic        rf_wen, csr_wen, halt, trap;
  logic [1:0]  cause;
  logic [2:0]  st;
  int          checks = 0;
  int          failures = 0;
  exp_t        sb[$];

  npc_ctrl_fsm_if bus();

  npc_ctrl_fsm #(.RESET_PC(32'h8000_0000), .TIMEOUT(16), .CNT_W(32)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .start_i         (start),
    .bus             (bus.master),
    .ir_o            (ir),
    .decode_optype_i (dec_type),
    .decode_option_i (dec_opt),
    .next_pc_i       (next_pc),
    .rf_wen_o        (rf_wen),
    .csr_wen_o       (csr_wen),
    .pc_o            (pc),
    .halt_o          (halt),
    .trap_o          (trap),
    .trap_cause_o    (cause),
    .state_o         (st),
    .inst_cnt_o      (cnt)
  );

  always #5 clk = ~clk;

  // Decoder model for the handful of encodings this bench fetches.
  always_comb begin
    dec_type = NOTYPE;
    dec_opt  = inst_addi;
    case (ir[6:0])
      7'h13: if (ir[14:12] == 3'd0) begin dec_type = TYPE_I; dec_opt = inst_addi; end
      7'h03: if (ir[14:12] == 3'd2) begin dec_type = TYPE_I; dec_opt = inst_lw; end
      7'h23: if (ir[14:12] == 3'd2) begin dec_type = TYPE_S; dec_opt = inst_sw; end
      7'h63: if (ir[14:12] == 3'd0) begin dec_type = TYPE_B; dec_opt = inst_beq; end
      7'h73: begin
        if (ir == 32'h0010_0073)      begin dec_type = TYPE_I; dec_opt = inst_ebreak; end
        else if (ir == 32'h0000_0073) begin dec_type = TYPE_I; dec_opt = inst_ecall; end
        else if (ir[14:12] == 3'd1)   begin dec_type = TYPE_I; dec_opt = inst_csrrw; end
      end
      default: ;
    endcase
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic exp_t mk(int cyc, int rf, int csr, int lval, int lwen,
                              logic [31:0] pc_e, logic [31:0] cnt_e, logic [2:0] st_e,
                              logic halt_e, logic trap_e, logic [1:0] cause_e);
    exp_t e;
    e.cyc = cyc; e.rf = rf; e.csr = csr; e.lval = lval; e.lwen = lwen;
    e.pc = pc_e; e.cnt = cnt_e; e.st = st_e; e.halt = halt_e; e.trap = trap_e; e.cause = cause_e;
    return e;
  endfunction

  // Serve the bus from FETCH until the next FETCH, halt, trap, MWAIT (if asked) or budget.
  task automatic serve(input logic [31:0] inst, input logic ierr, input bit iwh,
                       input int lstall, input logic lerr, input bit lwh, input bit stop_mw,
                       output int cyc, output int rf, output int csr, output int lval,
                       output int lwen, output bit to);
    bit ipend = 1'b0, lpend = 1'b0, i_hs, l_hs, i_rsp, l_rsp, done = 1'b0;
    cyc = 0; rf = 0; csr = 0; lval = 0; lwen = 0; to = 1'b0;
    while (!done) begin
      rf   += int'(rf_wen);
      csr  += int'(csr_wen);
      lval += int'(bus.lsu_req_valid_o);
      lwen += int'(bus.lsu_req_wen_o);
      bus.ifu_req_ready_i  = 1'b1;
      bus.ifu_resp_valid_i = ipend && !iwh;
      bus.ifu_resp_data_i  = inst;
      bus.ifu_resp_err_i   = ierr;
      bus.lsu_req_ready_i  = (lstall == 0);
      bus.lsu_resp_valid_i = lpend && !lwh;
      bus.lsu_resp_err_i   = lerr;
      i_hs  = bus.ifu_req_valid_o && bus.ifu_req_ready_i;
      l_hs  = bus.lsu_req_valid_o && bus.lsu_req_ready_i;
      i_rsp = bus.ifu_resp_valid_i;
      l_rsp = bus.lsu_resp_valid_i;
      if (bus.lsu_req_valid_o && lstall > 0) lstall--;
      tick();
      cyc++;
      if (i_rsp) ipend = 1'b0;
      if (i_hs)  ipend = 1'b1;
      if (l_rsp) lpend = 1'b0;
      if (l_hs)  lpend = 1'b1;
      if (bus.ifu_req_valid_o || halt || trap || (stop_mw && st == 3'd4 && !bus.lsu_req_valid_o))
        done = 1'b1;
      else if (cyc >= 100) begin
        done = 1'b1;
        to   = 1'b1;
      end
    end
    bus.ifu_resp_valid_i = 1'b0;
    bus.lsu_resp_valid_i = 1'b0;
    bus.ifu_req_ready_i  = 1'b0;
    bus.lsu_req_ready_i  = 1'b0;
  endtask

  task automatic run(input string tag, input exp_t e, input logic [31:0] addr_e,
                     input logic [31:0] inst, input logic [31:0] npc, input int lstall,
                     input logic ierr, input bit iwh, input logic lerr, input bit lwh,
                     input bit stop_mw);
    exp_t x;
    int   cyc, rf, csr, lval, lwen;
    bit   to;
    chk({tag, ".addr"}, bus.ifu_addr_o, addr_e);
    sb.push_back(e);
    next_pc = npc;
    serve(inst, ierr, iwh, lstall, lerr, lwh, stop_mw, cyc, rf, csr, lval, lwen, to);
    x = sb.pop_front();
    chk({tag, ".bound"}, 32'(to), 32'd0);
    chk({tag, ".cycles"}, cyc, x.cyc);
    chk({tag, ".rf_wen"}, rf, x.rf);
    chk({tag, ".csr_wen"}, csr, x.csr);
    chk({tag, ".lsu_valid"}, lval, x.lval);
    chk({tag, ".lsu_wen"}, lwen, x.lwen);
    chk({tag, ".pc"}, pc, x.pc);
    chk({tag, ".cnt"}, cnt, x.cnt);
    chk({tag, ".state"}, 32'(st), 32'(x.st));
    chk({tag, ".halt"}, 32'(halt), 32'(x.halt));
    chk({tag, ".trap"}, 32'(trap), 32'(x.trap));
    if (x.trap) chk({tag, ".cause"}, 32'(cause), 32'(x.cause));
  endtask

  task automatic restart();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    int quiet;
    bus.ifu_req_ready_i  = 1'b0;
    bus.ifu_resp_valid_i = 1'b0;
    bus.ifu_resp_data_i  = '0;
    bus.ifu_resp_err_i   = 1'b0;
    bus.lsu_req_ready_i  = 1'b0;
    bus.lsu_resp_valid_i = 1'b0;
    bus.lsu_resp_err_i   = 1'b0;

    tick();
    tick();
    chk("rst.state", 32'(st), 32'd0);
    chk("rst.pc", pc, 32'h8000_0000);
    chk("rst.ir", ir, 32'd0);
    chk("rst.cnt", cnt, 32'd0);
    chk("rst.ifu_valid", 32'(bus.ifu_req_valid_o), 32'd0);
    chk("rst.lsu_valid", 32'(bus.lsu_req_valid_o), 32'd0);
    chk("rst.flags", {28'd0, halt, trap, cause}, 32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle.ifu_valid", 32'(bus.ifu_req_valid_o), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("start.ifu_valid", 32'(bus.ifu_req_valid_o), 32'd1);
    chk("start.strobes", {30'd0, rf_wen, csr_wen}, 32'd0);
    chk("start.state", 32'(st), 32'd1);

    run("addi",   mk(5, 1, 0, 0, 0, 32'h8000_0004, 1, 3'd1, 0, 0, 0), 32'h8000_0000,
        32'h0050_0093, 32'h8000_0004, 0, 0, 0, 0, 0, 0);
    run("lw",     mk(10, 1, 0, 4, 0, 32'h8000_0008, 2, 3'd1, 0, 0, 0), 32'h8000_0004,
        32'h0000_a103, 32'h8000_0008, 3, 0, 0, 0, 0, 0);
    run("sw",     mk(7, 0, 0, 1, 1, 32'h8000_000C, 3, 3'd1, 0, 0, 0), 32'h8000_0008,
        32'h0020_a223, 32'h8000_000C, 0, 0, 0, 0, 0, 0);
    run("beq",    mk(5, 0, 0, 0, 0, 32'h8000_0040, 4, 3'd1, 0, 0, 0), 32'h8000_000C,
        32'h0020_8463, 32'h8000_0040, 0, 0, 0, 0, 0, 0);
    run("csrrw",  mk(5, 1, 1, 0, 0, 32'h8000_0044, 5, 3'd1, 0, 0, 0), 32'h8000_0040,
        32'h3050_92F3, 32'h8000_0044, 0, 0, 0, 0, 0, 0);
    run("ecall",  mk(5, 0, 0, 0, 0, 32'h8000_1000, 6, 3'd1, 0, 0, 0), 32'h8000_0044,
        32'h0000_0073, 32'h8000_1000, 0, 0, 0, 0, 0, 0);
    run("ebreak", mk(3, 0, 0, 0, 0, 32'h8000_1000, 7, 3'd6, 1, 0, 0), 32'h8000_1000,
        32'h0010_0073, 32'hDEAD_0000, 0, 0, 0, 0, 0, 0);
    quiet = 0;
    for (int i = 0; i < 50; i++) begin
      tick();
      quiet += int'(bus.ifu_req_valid_o);
    end
    chk("halt.no_fetch", quiet, 0);
    chk("halt.held", 32'(halt), 32'd1);

    restart();
    run("illegal", mk(3, 0, 0, 0, 0, 32'h8000_0000, 0, 3'd7, 0, 1, 2'd3), 32'h8000_0000,
        32'h0000_007F, 32'h8000_0004, 0, 0, 0, 0, 0, 0);
    chk("illegal.ir", ir, 32'h0000_007F);

    restart();
    run("timeout", mk(17, 0, 0, 0, 0, 32'h8000_0000, 0, 3'd7, 0, 1, 2'd2), 32'h8000_0000,
        32'h0050_0093, 32'h8000_0004, 0, 0, 1, 0, 0, 0);

    restart();
    run("ifu_err", mk(2, 0, 0, 0, 0, 32'h8000_0000, 0, 3'd7, 0, 1, 2'd0), 32'h8000_0000,
        32'h0050_0093, 32'h8000_0004, 0, 1, 0, 0, 0, 0);
    chk("ifu_err.ir", ir, 32'd0);

    restart();
    run("lsu_err", mk(6, 0, 0, 1, 0, 32'h8000_0000, 0, 3'd7, 0, 1, 2'd1), 32'h8000_0000,
        32'h0000_a103, 32'h8000_0004, 0, 0, 0, 1, 0, 0);

    restart();
    run("pre",   mk(5, 1, 0, 0, 0, 32'h8000_0004, 1, 3'd1, 0, 0, 0), 32'h8000_0000,
        32'h0050_0093, 32'h8000_0004, 0, 0, 0, 0, 0, 0);
    run("mwait", mk(5, 0, 0, 1, 0, 32'h8000_0004, 1, 3'd4, 0, 0, 0), 32'h8000_0004,
        32'h0000_a103, 32'h8000_0008, 0, 0, 0, 0, 1, 1);
    rst_n = 1'b0;
    #1;
    chk("arst.lsu_valid", 32'(bus.lsu_req_valid_o), 32'd0);
    chk("arst.pc", pc, 32'h8000_0000);
    chk("arst.state", 32'(st), 32'd0);
    chk("arst.cnt", cnt, 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("arst.idle", {30'd0, bus.ifu_req_valid_o, bus.lsu_req_valid_o}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
